// File: rtl/req_ack_responder.sv
// Four-phase req/ack responder: ack after a latched delay, abort flag, wrapping handshake counter.
// Latency: ack rises D edges after acceptance; all outputs registered; req is the only flow control.
module req_ack_responder #(
    parameter int DLY_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [DLY_W-1:0] dly_cfg,
    output logic             ack,
    output logic             busy,
    output logic             err_abort,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] done_nxt;
    logic             ack_nxt;
    logic             busy_nxt;
    logic             err_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done_cnt  <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            done_cnt  <= done_nxt;
            ack       <= ack_nxt;
            busy      <= busy_nxt;
            err_abort <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done_cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cnt_nxt   = dly_cfg;
                    state_nxt = (dly_cfg == '0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                // A req drop wins over the final countdown step.
                if (!req) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                    if (cnt == DLY_W'(1)) begin
                        state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (!req) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                done_nxt  = done_cnt + CNT_W'(1);
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so their registers line up with the state register.
    always_comb begin
        ack_nxt  = (state_nxt == S_ACK);
        busy_nxt = (state_nxt != S_IDLE);
        err_nxt  = (state == S_WAIT) && !req;
    end

endmodule

// File: tb/tb_req_ack_responder.sv
// Vector table for req_ack_responder: inputs driven at negedge, expectations queued and checked after posedge.
module tb_req_ack_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [3:0] dly_cfg;
    logic       ack;
    logic       busy;
    logic       err_abort;
    logic [7:0] done_cnt;

    req_ack_responder #(.DLY_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .dly_cfg   (dly_cfg),
        .ack       (ack),
        .busy      (busy),
        .err_abort (err_abort),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       req;
        logic [3:0] dly;
        logic       ack;
        logic       busy;
        logic       err;
        logic [7:0] done;
    } vec_t;

    typedef struct {
        int         id;
        logic       ack;
        logic       busy;
        logic       err;
        logic [7:0] done;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    logic [7:0] exp_done = 8'd0;
    int         checks   = 0;
    int         failures = 0;

    function automatic void add(input logic r, input logic q, input logic [3:0] d,
                                input logic a, input logic b, input logic e);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.dly   = d;
        v.ack   = a;
        v.busy  = b;
        v.err   = e;
        v.done  = exp_done;
        vecs.push_back(v);
    endfunction

    // Full handshake: accept with delay d, later cycles present dly_wait, drop req one cycle after ack.
    function automatic void hs(input int d, input logic [3:0] dly_wait);
        add(1'b1, 1'b1, 4'(d), d == 0, 1'b1, 1'b0);
        for (int k = 1; k <= d; k++) begin
            add(1'b1, 1'b1, dly_wait, k == d, 1'b1, 1'b0);
        end
        add(1'b1, 1'b0, dly_wait, 1'b0, 1'b1, 1'b0);
        exp_done = exp_done + 8'd1;
        add(1'b1, 1'b0, dly_wait, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, want);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ack",       e.id, {7'd0, ack},       {7'd0, e.ack});
                chk("busy",      e.id, {7'd0, busy},      {7'd0, e.busy});
                chk("err_abort", e.id, {7'd0, err_abort}, {7'd0, e.err});
                chk("done_cnt",  e.id, done_cnt,          e.done);
            end
        end
    end

    initial begin
        exp_t e;
        rst_n   = 1'b0;
        req     = 1'b0;
        dly_cfg = 4'd0;

        // Reset held with req high, then released with req low.
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Delay sweep.
        hs(0, 4'd0);
        hs(1, 4'd1);
        hs(5, 4'd5);
        hs(15, 4'd15);

        // Abort after 3 cycles of req with delay 6.
        add(1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);

        // Drop on the cnt==1 edge with delay 3, then an immediate D=0 accept proves IDLE.
        add(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        exp_done = exp_done + 8'd1;
        add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Accept with delay 4, config moves to 0 afterwards.
        hs(4, 4'd0);

        // Reset while ack is held.
        add(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        exp_done = 8'd0;
        add(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 257 back-to-back D=0 handshakes, req re-raised during DROP; counter wraps.
        for (int h = 0; h < 257; h++) begin
            add(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
            add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
            exp_done = exp_done + 8'd1;
            add(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            req     = vecs[i].req;
            dly_cfg = vecs[i].dly;
            e.id    = i;
            e.ack   = vecs[i].ack;
            e.busy  = vecs[i].busy;
            e.err   = vecs[i].err;
            e.done  = vecs[i].done;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
